// File: rtl/proc_boot_pkg.sv
// Shared types and defaults for the boot loader: FSM state encoding,
// default hold length and default run watchdog limit.
package proc_boot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HOLD    = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    localparam int          DEF_RESET_CYCLES = 2;
    localparam int          DEF_WD_W         = 16;
    localparam logic [15:0] DEF_WD_LIMIT     = 16'h00FF;

endpackage

// File: rtl/proc_boot_loader_if.sv
// Host/core-facing bundle of the boot loader. The loader sits on the slave modport.
// The checksum signal exists only when PROC_BOOT_CHECKSUM_EN is defined.
interface proc_boot_loader_if #(
    parameter int IMEM_AW = 6
);
    logic               go;
    logic [63:0]        start_pc;
    logic [63:0]        halt_pc;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_resetl;
    logic [63:0]        startpc;
    logic [63:0]        currentpc;
    logic [63:0]        MemtoRegOut;
    logic [63:0]        result;
    logic               busy;
    logic               done;
    logic               timeout;
    logic               overflow;
`ifdef PROC_BOOT_CHECKSUM_EN
    logic [31:0]        checksum;
`endif

    modport slave (
        input  go, start_pc, halt_pc, in_valid, in_data, in_last, currentpc, MemtoRegOut,
        output in_ready, imem_we, imem_addr, imem_wdata, core_resetl, startpc, result,
        output busy, done, timeout, overflow
`ifdef PROC_BOOT_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output go, start_pc, halt_pc, in_valid, in_data, in_last, currentpc, MemtoRegOut,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_resetl, startpc, result,
        input  busy, done, timeout, overflow
`ifdef PROC_BOOT_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface

// File: rtl/proc_boot_watchdog.sv
// Clearable up-counter with a terminal-count flag (count == limit), combinational flag.
// Clear has priority over enable; no backpressure.
module proc_boot_watchdog #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/proc_boot_loader.sv
// Loads a program into imem (1 word/cycle, write one cycle after transfer), holds then runs the core,
// ends on halt PC or watchdog; in_ready is registered from state. Optional PROC_BOOT_CHECKSUM_EN.
module proc_boot_loader
    import proc_boot_pkg::*;
#(
    parameter int              IMEM_AW      = 6,
    parameter int              RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int              WD_W         = DEF_WD_W,
    parameter logic [WD_W-1:0] WD_LIMIT     = WD_W'(DEF_WD_LIMIT)
) (
    input  logic             CLK,
    input  logic             reset,
    proc_boot_loader_if.slave bus
);

    localparam logic [IMEM_AW-1:0] LAST_ADDR = '1;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic [IMEM_AW-1:0] r_wcnt;
    logic               r_core_resetl;
    logic [63:0]        r_startpc;
    logic [63:0]        r_halt_pc;
    logic [63:0]        r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_overflow;

    logic               w_xfer;
    logic               w_go_ok;
    logic               w_wd_en;
    logic               w_wd_clr;
    logic               w_wd_tc;
    logic [WD_W-1:0]    w_wd_limit;

    assign w_xfer  = r_in_ready && bus.in_valid;
    assign w_go_ok = bus.go && (r_state == IDLE || r_state == DONE || r_state == TIMEOUT);

    // One counter serves both the HOLD length and the RUN watchdog; it restarts at each phase entry.
    assign w_wd_en    = (r_state == HOLD) || (r_state == RUN);
    assign w_wd_clr   = !w_wd_en || ((r_state == HOLD) && w_wd_tc);
    assign w_wd_limit = (r_state == HOLD) ? WD_W'(RESET_CYCLES - 1) : WD_LIMIT;

    proc_boot_watchdog #(.W(WD_W)) u_wd (
        .CLK     (CLK),
        .reset   (reset),
        .i_clr   (w_wd_clr),
        .i_en    (w_wd_en),
        .i_limit (w_wd_limit),
        .o_tc    (w_wd_tc)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_in_ready    <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= '0;
            r_wcnt        <= '0;
            r_core_resetl <= 1'b0;
            r_startpc     <= '0;
            r_halt_pc     <= '0;
            r_result      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                IDLE, DONE, TIMEOUT: begin
                    if (w_go_ok) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                        r_wcnt     <= '0;
                        r_overflow <= 1'b0;
                        r_startpc  <= bus.start_pc;
                        r_halt_pc  <= bus.halt_pc;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_wcnt;
                        r_imem_wdata <= bus.in_data;
                        r_wcnt       <= r_wcnt + 1'b1;
                        // A full memory without in_last means the program was cut short.
                        if (bus.in_last || (r_wcnt == LAST_ADDR)) begin
                            r_state    <= HOLD;
                            r_in_ready <= 1'b0;
                            r_overflow <= !bus.in_last;
                        end
                    end
                end
                HOLD: begin
                    if (w_wd_tc) begin
                        r_state       <= RUN;
                        r_core_resetl <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.currentpc >= r_halt_pc) begin
                        r_state       <= DONE;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_core_resetl <= 1'b0;
                        r_result      <= bus.MemtoRegOut;
                    end else if (w_wd_tc) begin
                        r_state       <= TIMEOUT;
                        r_timeout     <= 1'b1;
                        r_busy        <= 1'b0;
                        r_core_resetl <= 1'b0;
                        r_result      <= bus.MemtoRegOut;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PROC_BOOT_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_go_ok) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= {r_checksum[30:0], r_checksum[31]} ^ bus.in_data;
        end
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.in_ready    = r_in_ready;
    assign bus.imem_we     = r_imem_we;
    assign bus.imem_addr   = r_imem_addr;
    assign bus.imem_wdata  = r_imem_wdata;
    assign bus.core_resetl = r_core_resetl;
    assign bus.startpc     = r_startpc;
    assign bus.result      = r_result;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout     = r_timeout;
    assign bus.overflow    = r_overflow;

endmodule
